// File: rtl/pulse_gen_pkg.sv
// Shared types and default widths for the pulse train generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pulse_gen_pkg;

    localparam int PG_WIDTH_DEF    = 32;
    localparam int PG_PW_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pg_state_t;

endpackage

// File: rtl/pulse_train_gen_phase_timer.sv
// Loadable down-counter timing one high or low phase of the pulse train.
// Latency: expire asserts in the load_val-th cycle after the load edge (load_val >= 1).
// Backpressure: none; load always wins over counting.
// Ports: clk, reset (async active-low), load/load_val (start a phase), expire (last cycle of phase).
module phase_timer #(
    parameter int PW_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [PW_WIDTH-1:0] load_val,
    output logic                expire
);

    localparam logic [PW_WIDTH-1:0] ONE = {{(PW_WIDTH-1){1'b0}}, 1'b1};

    logic [PW_WIDTH-1:0] cnt_d;
    logic [PW_WIDTH-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A phase loaded with V occupies V cycles; the last one sees cnt_q == 1.
    assign expire = (cnt_q == ONE);

endmodule

// File: rtl/pulse_train_gen.sv
// Emits N pulses of H' high / L' low cycles on a flopped output, reporting completion with done.
// Latency: signal rises on the accept edge; train ends N*(H'+L') edges later, done in the following cycle.
// Backpressure: cmd_ready high only in IDLE; abort ends an active train, done strobes next cycle.
// Ports: cmd_valid/cmd_ready + cmd_count/cmd_high/cmd_low, abort, signal, busy, done, pulses_sent.
module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int WIDTH    = PG_WIDTH_DEF,
    parameter int PW_WIDTH = PG_PW_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [WIDTH-1:0]    cmd_count,
    input  logic [PW_WIDTH-1:0] cmd_high,
    input  logic [PW_WIDTH-1:0] cmd_low,
    input  logic                abort,
    output logic                signal,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    pulses_sent
);

    localparam logic [PW_WIDTH-1:0] PW_ONE = {{(PW_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]    N_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    pg_state_t           state_d,  state_q;
    logic                signal_d, signal_q;
    logic                done_d,   done_q;
    logic [WIDTH-1:0]    pulses_d, pulses_q;
    logic [WIDTH-1:0]    count_d,  count_q;
    logic [PW_WIDTH-1:0] high_d,   high_q;
    logic [PW_WIDTH-1:0] low_d,    low_q;

    logic                tmr_load;
    logic [PW_WIDTH-1:0] tmr_val;
    logic                tmr_expire;
    logic [PW_WIDTH-1:0] cmd_high_eff;
    logic [PW_WIDTH-1:0] cmd_low_eff;

    // Zero-length phases would never expire; run them as one cycle.
    assign cmd_high_eff = (cmd_high == '0) ? PW_ONE : cmd_high;
    assign cmd_low_eff  = (cmd_low  == '0) ? PW_ONE : cmd_low;

    phase_timer #(
        .PW_WIDTH (PW_WIDTH)
    ) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        signal_d = signal_q;
        done_d   = 1'b0;
        pulses_d = pulses_q;
        count_d  = count_q;
        high_d   = high_q;
        low_d    = low_q;
        tmr_load = 1'b0;
        tmr_val  = high_q;

        case (state_q)
            IDLE: begin
                // abort is irrelevant here; a presented command is always taken.
                if (cmd_valid) begin
                    count_d = cmd_count;
                    high_d  = cmd_high_eff;
                    low_d   = cmd_low_eff;
                    if (cmd_count == '0) begin
                        done_d   = 1'b1;
                        pulses_d = '0;
                    end else begin
                        state_d  = HIGH;
                        signal_d = 1'b1;
                        pulses_d = N_ONE;
                        tmr_load = 1'b1;
                        tmr_val  = cmd_high_eff;
                    end
                end
            end
            HIGH: begin
                if (abort) begin
                    state_d  = IDLE;
                    signal_d = 1'b0;
                    done_d   = 1'b1;
                end else if (tmr_expire) begin
                    state_d  = LOW;
                    signal_d = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = low_q;
                end
            end
            LOW: begin
                if (abort) begin
                    state_d  = IDLE;
                    signal_d = 1'b0;
                    done_d   = 1'b1;
                end else if (tmr_expire) begin
                    if (pulses_q < count_q) begin
                        state_d  = HIGH;
                        signal_d = 1'b1;
                        pulses_d = pulses_q + N_ONE;
                        tmr_load = 1'b1;
                        tmr_val  = high_q;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                signal_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            signal_q <= 1'b0;
            done_q   <= 1'b0;
            pulses_q <= '0;
            count_q  <= '0;
            high_q   <= PW_ONE;
            low_q    <= PW_ONE;
        end else begin
            state_q  <= state_d;
            signal_q <= signal_d;
            done_q   <= done_d;
            pulses_q <= pulses_d;
            count_q  <= count_d;
            high_q   <= high_d;
            low_q    <= low_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = !cmd_ready;
    assign signal      = signal_q;
    assign done        = done_q;
    assign pulses_sent = pulses_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: reset, normal trains, zero widths, N=0, abort, async reset, back-to-back.
// Latency: outputs sampled on the falling clock edge.
// Backpressure: commands only issued while the block is idle (or held valid for back-to-back).
module tb_pulse_train_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_count;
    logic [15:0] cmd_high;
    logic [15:0] cmd_low;
    logic        abort;
    logic        signal;
    logic        busy;
    logic        done;
    logic [31:0] pulses_sent;

    int checks = 0;
    int errors = 0;

    pulse_train_gen dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_count   (cmd_count),
        .cmd_high    (cmd_high),
        .cmd_low     (cmd_low),
        .abort       (abort),
        .signal      (signal),
        .busy        (busy),
        .done        (done),
        .pulses_sent (pulses_sent)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present a command at a falling edge, let it be taken at the next rising
    // edge, scramble the inputs, and return at the first sample after accept.
    task automatic send(input logic [31:0] n, input logic [15:0] h, input logic [15:0] l);
        cmd_valid = 1'b1;
        cmd_count = n;
        cmd_high  = h;
        cmd_low   = l;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_count = 32'h0000_0007;
        cmd_high  = 16'h0009;
        cmd_low   = 16'h0005;
        @(negedge clk);
    endtask

    initial begin
        logic [8:0] pat9;
        logic [7:0] pat8;
        logic [8:0] dpat9;
        logic       prev;
        int         rises;
        int         falls;

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_count = '0;
        cmd_high  = '0;
        cmd_low   = '0;
        abort     = 1'b0;

        // Reset state
        #12;
        chk("rst_signal", signal, 0);
        chk("rst_done", done, 0);
        chk("rst_pulses", pulses_sent, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // N=3 H=2 L=1: 110110110, done in the cycle after 9 busy cycles
        pat9  = 9'b110110110;
        prev  = 1'b0;
        rises = 0;
        falls = 0;
        send(32'd3, 16'd2, 16'd1);
        for (int i = 0; i < 9; i++) begin
            chk("t1_signal", signal, pat9[8-i]);
            chk("t1_busy", busy, 1);
            chk("t1_done_low", done, 0);
            if (signal && !prev) rises++;
            if (!signal && prev) falls++;
            prev = signal;
            @(negedge clk);
        end
        if (!signal && prev) falls++;
        chk("t1_rises", rises, 3);
        chk("t1_falls", falls, 3);
        chk("t1_done", done, 1);
        chk("t1_ready", cmd_ready, 1);
        chk("t1_pulses", pulses_sent, 3);
        chk("t1_end_low", signal, 0);
        @(negedge clk);
        chk("t1_done_strobe", done, 0);

        // N=0: no pulse, done next cycle, ready stays high, count cleared
        send(32'd0, 16'd5, 16'd5);
        chk("t2_done", done, 1);
        chk("t2_ready", cmd_ready, 1);
        chk("t2_signal", signal, 0);
        chk("t2_pulses", pulses_sent, 0);
        @(negedge clk);
        chk("t2_done_strobe", done, 0);
        chk("t2_signal2", signal, 0);

        // H=0 L=0 N=4: treated as 1/1 -> 10101010 over 8 busy cycles
        pat8 = 8'b10101010;
        send(32'd4, 16'd0, 16'd0);
        for (int i = 0; i < 8; i++) begin
            chk("t3_signal", signal, pat8[7-i]);
            chk("t3_busy", busy, 1);
            @(negedge clk);
        end
        chk("t3_done", done, 1);
        chk("t3_pulses", pulses_sent, 4);
        chk("t3_busy_end", busy, 0);
        @(negedge clk);

        // Abort during 2nd high phase of N=5 H=3 L=3
        send(32'd5, 16'd3, 16'd3);
        repeat (6) @(negedge clk);
        chk("t4_second_high", signal, 1);
        chk("t4_pulses_mid", pulses_sent, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_signal", signal, 0);
        chk("t4_done", done, 1);
        chk("t4_pulses", pulses_sent, 2);
        chk("t4_ready", cmd_ready, 1);
        @(negedge clk);
        chk("t4_done_strobe", done, 0);
        chk("t4_pulses_hold", pulses_sent, 2);

        // abort together with cmd_valid in IDLE: command wins
        abort = 1'b1;
        send(32'd1, 16'd1, 16'd1);
        abort = 1'b0;
        chk("t5_signal", signal, 1);
        chk("t5_busy", busy, 1);
        @(negedge clk);
        chk("t5_low", signal, 0);
        @(negedge clk);
        chk("t5_done", done, 1);
        chk("t5_pulses", pulses_sent, 1);
        @(negedge clk);

        // Asynchronous reset in the middle of a high phase
        send(32'd2, 16'd4, 16'd4);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("t6_signal", signal, 0);
        chk("t6_pulses", pulses_sent, 0);
        chk("t6_ready", cmd_ready, 1);
        chk("t6_busy", busy, 0);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("t6_idle", cmd_ready, 1);
        send(32'd1, 16'd2, 16'd1);
        chk("t6_run0", signal, 1);
        @(negedge clk);
        chk("t6_run1", signal, 1);
        @(negedge clk);
        chk("t6_run2", signal, 0);
        @(negedge clk);
        chk("t6_done", done, 1);
        chk("t6_pulses_after", pulses_sent, 1);
        @(negedge clk);

        // Back-to-back N=1 H=1 L=1 with cmd_valid held: each new command is
        // taken at the edge closing the done cycle.
        pat9      = 9'b100100100;
        dpat9     = 9'b001001001;
        cmd_valid = 1'b1;
        cmd_count = 32'd1;
        cmd_high  = 16'd1;
        cmd_low   = 16'd1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            chk("t7_signal", signal, pat9[8-i]);
            chk("t7_done", done, dpat9[8-i]);
            if (i == 6) cmd_valid = 1'b0;
            @(negedge clk);
        end
        chk("t7_idle_done", done, 0);
        chk("t7_idle_ready", cmd_ready, 1);
        chk("t7_pulses", pulses_sent, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
